idu_fetch_rd: RTL and testbench
===============================

Name: idu_fetch_rd

Overview:
- Decode-side reader of the instruction FIFO inside the instruction fetch unit.
- Pops instruction words with idu2ifu_rd_rqst and captures the returned word on ifu2idu_rdata/ifu2idu_rdata_valid.
- Holds returned words in a small credit-controlled prefetch buffer and presents them to the decoder on a valid/ready handshake.
- Supports pipeline flush, fetch enable, a retired-instruction counter and a protocol-error flag.

Parameters:
- FIFO_WIDTH, 32, instruction word width; must equal the fetch unit FIFO width.
- BUF_DEPTH, 2, prefetch buffer entries; power of two, at least 2.
- CNT_WIDTH, 16, width of the delivered-instruction counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- ifu2idu_fifo_empty  in  1  fetch unit FIFO empty.
- ifu2idu_rdata  in  FIFO_WIDTH  read data from the fetch unit.
- ifu2idu_rdata_valid  in  1  read data valid.
- idu2ifu_rd_rqst  out  1  FIFO pop request.
- fetch_en  in  1  allow new pop requests.
- flush  in  1  discard buffered and in-flight words.
- dec_instr  out  FIFO_WIDTH  instruction at buffer head.
- dec_instr_valid  out  1  dec_instr holds a valid word.
- dec_ready  in  1  decoder accepts dec_instr.
- instr_count  out  CNT_WIDTH  instructions delivered since reset.
- buf_level  out  $clog2(BUF_DEPTH)+1  current buffer occupancy.
- err_unexp_valid  out  1  sticky flag: valid data arrived with no request outstanding.

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous and active-low (rstn sampled on the clk rising edge).
  - During and after reset: all outputs are 0; buffer empty; inflight=0; drop=0.
- Read protocol with the fetch unit:
  - A pop is accepted when idu2ifu_rd_rqst=1 and ifu2idu_fifo_empty=0 in the same cycle.
  - For every accepted pop, ifu2idu_rdata_valid=1 exactly one cycle later with the word on ifu2idu_rdata.
  - At most one request is outstanding; the inflight register is set on accept and cleared on the next cycle.
- Request generation (combinational from registered state and inputs):
  - idu2ifu_rd_rqst = fetch_en & ~ifu2idu_fifo_empty & ~flush & credit.
  - credit = (buf_level + inflight < BUF_DEPTH), or (buf_level + inflight == BUF_DEPTH and a pop occurs this cycle).
  - The buffer therefore never overflows. Back-to-back requests (one per cycle) are allowed while credit holds.
- Capture:
  - rdata_valid=1, inflight=1, drop=0: the word is written at the write pointer.
  - rdata_valid=1 with drop=1: the word is discarded; drop clears.
  - rdata_valid=1 with inflight=0: the word is discarded and err_unexp_valid is set until reset.
- Decoder handshake:
  - dec_instr_valid = (buf_level != 0).
  - dec_instr = head entry, driven directly from the buffer, so data is stable while valid and not ready.
  - A pop occurs when dec_instr_valid & dec_ready. The read pointer advances and instr_count increments, wrapping modulo 2^CNT_WIDTH.
- Simultaneous events:
  - Push and pop in the same cycle: buf_level unchanged, both pointers advance.
  - Push into an empty buffer: the word appears on dec_instr the next cycle (capture-to-output latency 1; request-to-output latency 2).
- Flush:
  - Pointers and buf_level clear next cycle; idu2ifu_rd_rqst is forced 0 in the flush cycle.
  - If inflight=1 in the flush cycle, drop is set so the returning word is discarded.
  - A pop coincident with flush is not counted.
  - Flush with an empty buffer and nothing in flight has no effect other than suppressing the request.
  - err_unexp_valid is not cleared by flush.
- fetch_en=0: no new requests; an in-flight word is still captured; the decoder still drains the buffer.
- Pointers wrap modulo BUF_DEPTH. buf_level ranges 0..BUF_DEPTH.
- Reset asserted mid-operation: state clears at that edge. A word returning the following cycle finds inflight=0 and sets err_unexp_valid. The fetch unit is reset together with this block, so this case does not arise in-system.

Test Plan:
- Basic stream: fifo holds 0xA0,0xA1,0xA2; fetch_en=1, dec_ready=1 -> rd_rqst on cycles 0,1,2; dec_instr 0xA0/0xA1/0xA2 valid on cycles 2,3,4; instr_count=3.
- Backpressure: dec_ready=0 -> exactly BUF_DEPTH (2) pops accepted, then rd_rqst=0; buf_level=2; dec_instr held 0xA0. Raise dec_ready -> delivery resumes in order with no loss or duplication.
- Flush with word in flight: flush the cycle after a request is accepted -> returning word discarded, buf_level=0, dec_instr_valid=0. The next fetched word 0xB0 is delivered and instr_count does not include the discarded word.
- Empty FIFO and enable: ifu2idu_fifo_empty=1 or fetch_en=0 -> rd_rqst stays 0. Drop fetch_en with one word in flight -> that word is still delivered.
- Unexpected valid: pulse rdata_valid with no request -> err_unexp_valid=1 and stays 1 through a flush; buffer unchanged; clears only on rstn=0.
- Counter wrap: CNT_WIDTH=4, deliver 17 instructions -> instr_count=1. Synchronous reset mid-stream -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/idu_fetch_rd.sv
// rtl/idu_fetch_rd.sv - decode-side reader of the fetch unit instruction FIFO
module idu_fetch_rd #(
    parameter int FIFO_WIDTH = 32,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         ifu2idu_fifo_empty,
    input  logic [FIFO_WIDTH-1:0]        ifu2idu_rdata,
    input  logic                         ifu2idu_rdata_valid,
    output logic                         idu2ifu_rd_rqst,
    input  logic                         fetch_en,
    input  logic                         flush,
    output logic [FIFO_WIDTH-1:0]        dec_instr,
    output logic                         dec_instr_valid,
    input  logic                         dec_ready,
    output logic [CNT_WIDTH-1:0]         instr_count,
    output logic [$clog2(BUF_DEPTH):0]   buf_level,
    output logic                         err_unexp_valid
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W:0] DEPTH_W = (LVL_W+1)'(BUF_DEPTH);

    logic [FIFO_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [LVL_W-1:0]      level;
    logic                  inflight, drop, err;
    logic [CNT_WIDTH-1:0]  count;

    logic                  pop, push, credit, drop_next;
    logic [LVL_W:0]        occupied;

    always_comb begin
        pop       = (level != '0) & dec_ready;
        occupied  = {1'b0, level} + {{LVL_W{1'b0}}, inflight};
        // A slot freed by this cycle's decoder pop may be reused by a new request
        credit    = (occupied < DEPTH_W) | ((occupied == DEPTH_W) & pop);
        idu2ifu_rd_rqst = fetch_en & ~ifu2idu_fifo_empty & ~flush & credit;
        push      = ifu2idu_rdata_valid & inflight & ~drop & ~flush;
        // A word still owed after a flush is swallowed when it eventually shows up
        drop_next = (drop | (flush & inflight)) & ~ifu2idu_rdata_valid;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ifu2idu_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
            err      <= 1'b0;
            count    <= '0;
        end else begin
            inflight <= idu2ifu_rd_rqst;
            drop     <= drop_next;
            if (ifu2idu_rdata_valid & ~inflight & ~drop) err <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    count  <= count + CNT_WIDTH'(1);
                end
                case ({push, pop})
                    2'b10:   level <= level + LVL_W'(1);
                    2'b01:   level <= level - LVL_W'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    assign dec_instr_valid = (level != '0);
    assign dec_instr       = dec_instr_valid ? mem[rd_ptr] : '0;
    assign instr_count     = count;
    assign buf_level       = level;
    assign err_unexp_valid = err;
endmodule

// File: tb/tb_idu_fetch_rd.sv
// tb/tb_idu_fetch_rd.sv - directed table-driven bench for idu_fetch_rd
module tb_idu_fetch_rd;
    logic        clk, rstn;
    logic        ifu2idu_fifo_empty, ifu2idu_rdata_valid, idu2ifu_rd_rqst;
    logic [31:0] ifu2idu_rdata, dec_instr;
    logic        fetch_en, flush, dec_instr_valid, dec_ready, err_unexp_valid;
    logic [3:0]  instr_count;
    logic [1:0]  buf_level;

    idu_fetch_rd #(.FIFO_WIDTH(32), .BUF_DEPTH(2), .CNT_WIDTH(4)) dut (
        .clk(clk), .rstn(rstn),
        .ifu2idu_fifo_empty(ifu2idu_fifo_empty),
        .ifu2idu_rdata(ifu2idu_rdata),
        .ifu2idu_rdata_valid(ifu2idu_rdata_valid),
        .idu2ifu_rd_rqst(idu2ifu_rd_rqst),
        .fetch_en(fetch_en), .flush(flush),
        .dec_instr(dec_instr), .dec_instr_valid(dec_instr_valid),
        .dec_ready(dec_ready), .instr_count(instr_count),
        .buf_level(buf_level), .err_unexp_valid(err_unexp_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        add;
        logic [31:0] add_w;
        logic        fe, rdy;
        logic        rq, v;
        logic [31:0] instr;
        logic [1:0]  lvl;
        logic [3:0]  cnt;
    } vec_t;

    vec_t        tbl [18];
    logic [31:0] fifo_q [$];
    logic [31:0] got [$];
    logic [31:0] ret_word;
    logic        ret_pending, inj;
    logic        last_rqst, last_valid, last_err;
    logic [31:0] last_instr;
    logic [1:0]  last_level;
    logic [3:0]  last_count;
    int          checks, failures;

    task automatic row(input int i, input logic add, input logic [31:0] w,
                       input logic fe, input logic rdy, input logic rq, input logic v,
                       input logic [31:0] instr, input logic [1:0] lvl, input logic [3:0] cnt);
        tbl[i].add = add; tbl[i].add_w = w; tbl[i].fe = fe; tbl[i].rdy = rdy;
        tbl[i].rq = rq; tbl[i].v = v; tbl[i].instr = instr; tbl[i].lvl = lvl; tbl[i].cnt = cnt;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock cycle: drive fetch-unit inputs, sample outputs mid-cycle, advance model
    task automatic tick();
        logic acc;
        ifu2idu_fifo_empty  = (fifo_q.size() == 0);
        ifu2idu_rdata_valid = ret_pending | inj;
        ifu2idu_rdata       = ret_pending ? ret_word : 32'hDEAD_0000;
        #1;
        last_rqst  = idu2ifu_rd_rqst;
        last_valid = dec_instr_valid;
        last_instr = dec_instr;
        last_level = buf_level;
        last_count = instr_count;
        last_err   = err_unexp_valid;
        acc = idu2ifu_rd_rqst & ~ifu2idu_fifo_empty;
        if (dec_instr_valid & dec_ready) got.push_back(dec_instr);
        @(posedge clk);
        ret_pending = acc;
        if (acc) ret_word = fifo_q.pop_front();
        if (!rstn) begin
            ret_pending = 1'b0;
            fifo_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rqst"},  {31'd0, last_rqst},  32'd0);
        chk({tag, "_valid"}, {31'd0, last_valid}, 32'd0);
        chk({tag, "_instr"}, last_instr,          32'd0);
        chk({tag, "_level"}, {30'd0, last_level}, 32'd0);
        chk({tag, "_count"}, {28'd0, last_count}, 32'd0);
        chk({tag, "_err"},   {31'd0, last_err},   32'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        rstn = 1'b0; fetch_en = 1'b0; flush = 1'b0; dec_ready = 1'b0;
        inj = 1'b0; ret_pending = 1'b0; ret_word = '0;
        ifu2idu_fifo_empty = 1'b1; ifu2idu_rdata_valid = 1'b0; ifu2idu_rdata = '0;
        @(negedge clk);
        tick();
        tick();
        chk_reset_outputs("reset");
        rstn = 1'b1;

        //   i  add  word        fe rdy rq v  instr        lvl cnt
        row(0,  0, 32'h0,        1, 1,  1, 0, 32'h0,       0,  0);
        row(1,  0, 32'h0,        1, 1,  1, 0, 32'h0,       0,  0);
        row(2,  0, 32'h0,        1, 1,  1, 1, 32'hA0,      1,  0);
        row(3,  0, 32'h0,        1, 1,  0, 1, 32'hA1,      1,  1);
        row(4,  0, 32'h0,        1, 1,  0, 1, 32'hA2,      1,  2);
        row(5,  0, 32'h0,        1, 1,  0, 0, 32'h0,       0,  3);
        row(6,  1, 32'hC0,       0, 0,  0, 0, 32'h0,       0,  3);
        row(7,  1, 32'hC1,       0, 0,  0, 0, 32'h0,       0,  3);
        row(8,  1, 32'hC2,       0, 0,  0, 0, 32'h0,       0,  3);
        row(9,  0, 32'h0,        1, 0,  1, 0, 32'h0,       0,  3);
        row(10, 0, 32'h0,        1, 0,  1, 0, 32'h0,       0,  3);
        row(11, 0, 32'h0,        1, 0,  0, 1, 32'hC0,      1,  3);
        row(12, 0, 32'h0,        1, 0,  0, 1, 32'hC0,      2,  3);
        row(13, 0, 32'h0,        1, 0,  0, 1, 32'hC0,      2,  3);
        row(14, 0, 32'h0,        1, 1,  1, 1, 32'hC0,      2,  3);
        row(15, 0, 32'h0,        1, 1,  0, 1, 32'hC1,      1,  4);
        row(16, 0, 32'h0,        1, 1,  0, 1, 32'hC2,      1,  5);
        row(17, 0, 32'h0,        1, 1,  0, 0, 32'h0,       0,  6);

        fifo_q.push_back(32'hA0); fifo_q.push_back(32'hA1); fifo_q.push_back(32'hA2);
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].add) fifo_q.push_back(tbl[i].add_w);
            fetch_en  = tbl[i].fe;
            dec_ready = tbl[i].rdy;
            tick();
            chk($sformatf("row%0d_rqst", i),  {31'd0, last_rqst},  {31'd0, tbl[i].rq});
            chk($sformatf("row%0d_valid", i), {31'd0, last_valid}, {31'd0, tbl[i].v});
            if (tbl[i].v) chk($sformatf("row%0d_instr", i), last_instr, tbl[i].instr);
            chk($sformatf("row%0d_level", i), {30'd0, last_level}, {30'd0, tbl[i].lvl});
            chk($sformatf("row%0d_count", i), {28'd0, last_count}, {28'd0, tbl[i].cnt});
        end

        // flush while a word is in flight
        fifo_q.push_back(32'hD0);
        fetch_en = 1'b1; dec_ready = 1'b1;
        tick();
        chk("flush_pre_rqst", {31'd0, last_rqst}, 32'd1);
        flush = 1'b1; fifo_q.push_back(32'hB0);
        tick();
        chk("flush_rqst_forced", {31'd0, last_rqst}, 32'd0);
        flush = 1'b0;
        tick();
        chk("flush_level",  {30'd0, last_level}, 32'd0);
        chk("flush_valid",  {31'd0, last_valid}, 32'd0);
        chk("flush_refetch", {31'd0, last_rqst}, 32'd1);
        tick();
        chk("flush_capture_valid", {31'd0, last_valid}, 32'd0);
        tick();
        chk("flush_b0_valid", {31'd0, last_valid}, 32'd1);
        chk("flush_b0_instr", last_instr, 32'hB0);
        chk("flush_b0_count", {28'd0, last_count}, 32'd6);
        tick();
        chk("flush_after_valid", {31'd0, last_valid}, 32'd0);
        chk("flush_after_count", {28'd0, last_count}, 32'd7);
        chk("flush_no_err", {31'd0, last_err}, 32'd0);

        // empty FIFO, fetch disable, and in-flight word under fetch_en=0
        tick();
        chk("empty_rqst", {31'd0, last_rqst}, 32'd0);
        fetch_en = 1'b0; fifo_q.push_back(32'hE0);
        tick();
        chk("disabled_rqst", {31'd0, last_rqst}, 32'd0);
        fetch_en = 1'b1;
        tick();
        chk("enable_rqst", {31'd0, last_rqst}, 32'd1);
        fetch_en = 1'b0;
        tick();
        tick();
        chk("inflight_e0_valid", {31'd0, last_valid}, 32'd1);
        chk("inflight_e0_instr", last_instr, 32'hE0);
        tick();
        chk("inflight_e0_count", {28'd0, last_count}, 32'd8);

        // unexpected valid
        inj = 1'b1;
        tick();
        inj = 1'b0;
        tick();
        chk("unexp_err",   {31'd0, last_err},   32'd1);
        chk("unexp_level", {30'd0, last_level}, 32'd0);
        chk("unexp_valid", {31'd0, last_valid}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("unexp_err_after_flush", {31'd0, last_err}, 32'd1);
        rstn = 1'b0;
        tick();
        tick();
        chk_reset_outputs("err_reset");
        rstn = 1'b1;

        // counter wrap with a 4-bit counter
        for (int k = 0; k < 17; k++) fifo_q.push_back(32'hF00 + k);
        got.delete();
        fetch_en = 1'b1; dec_ready = 1'b1;
        for (int t = 0; t < 80 && got.size() < 17; t++) tick();
        chk("wrap_delivered", got.size(), 32'd17);
        for (int k = 0; k < 17 && k < got.size(); k++)
            chk($sformatf("wrap_word%0d", k), got[k], 32'hF00 + k);
        tick();
        chk("wrap_count", {28'd0, last_count}, 32'd1);

        // synchronous reset mid-stream
        for (int k = 0; k < 6; k++) fifo_q.push_back(32'h700 + k);
        tick();
        tick();
        tick();
        chk("midstream_active", {31'd0, last_valid}, 32'd1);
        rstn = 1'b0; fetch_en = 1'b0;
        tick();
        tick();
        chk_reset_outputs("midstream_reset");
        rstn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
